// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a prefetch buffer.
//   Owns the fetch PC and issues pipelined in-order reads to instruction
//   memory. Responses are buffered together with their PCs and handed to
//   decode over valid/ready. A redirect flushes the buffer, restarts fetch
//   at a new address and discards responses still in flight.
//
// Optional build macro: FETCH_MISALIGN_CHK_EN
//   defined   : a redirect to a non word-aligned address raises a sticky
//               fault_o and blocks requests until an aligned redirect or rst.
//   undefined : redirect_pc_i[1:0] is ignored (treated as 0); fault_o = 0.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   imem_req_o      read request            imem_addr_o   request address
//   imem_gnt_i      request accepted        imem_rvalid_i response valid
//   imem_rdata_i    response instruction
//   redirect_i      flush + restart         redirect_pc_i restart address
//   instr_valid_o   buffer head valid       instr_ready_i decode accepts head
//   instr_o         head instruction        instr_pc_o    head PC
//   fault_o         misaligned-redirect fault
module fetch_queue #(
  parameter int unsigned        XLEN     = 32,
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [XLEN-1:0]   imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [XLEN-1:0]   instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              fault_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_discard;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [XLEN-1:0]   r_buf_instr [DEPTH];
  logic [ADDR_W-1:0] r_buf_pc    [DEPTH];

  logic [ADDR_W-1:0] w_redirect_pc;
  logic              w_fault;
  logic              w_empty;
  logic [CW:0]       w_inflight;
  logic              w_grant;
  logic              w_rsp;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_out_next;

  assign w_redirect_pc = {redirect_pc_i[ADDR_W-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_fault;
  logic w_misaligned;

  assign w_misaligned = |redirect_pc_i[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (redirect_i) begin
      r_fault <= w_misaligned;
    end
  end

  assign w_fault = r_fault;
`else
  logic w_unused_pc_lsb;
  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];
  assign w_fault         = 1'b0;
`endif

  assign fault_o = w_fault;

  // Credit rule: buffered + outstanding never exceeds DEPTH, so every
  // granted request has a guaranteed buffer slot when its response lands.
  assign w_empty    = (r_count == '0);
  assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req_o = !redirect_i && !w_fault && (w_inflight < DEPTH_W);
  assign imem_addr_o = r_fetch_pc;

  assign w_grant = imem_req_o && imem_gnt_i;
  assign w_rsp   = imem_rvalid_i && (r_outstanding != '0);
  assign w_drop  = w_rsp && (r_discard != '0);
  assign w_push  = w_rsp && !w_drop && !redirect_i;

  assign instr_valid_o = !w_empty && !redirect_i;
  assign w_pop         = instr_valid_o && instr_ready_i;
  assign instr_o       = w_empty ? '0 : r_buf_instr[r_rd_ptr];
  assign instr_pc_o    = w_empty ? '0 : r_buf_pc[r_rd_ptr];

  always_comb begin
    w_out_next = r_outstanding;
    if (w_grant) begin
      w_out_next = w_out_next + CW'(1);
    end
    if (w_rsp) begin
      w_out_next = w_out_next - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_i) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        // No grant can happen in a redirect cycle, so w_out_next is exactly
        // the set of responses still owed by the flushed stream. r_discard is
        // always a subset of r_outstanding, so it is replaced, not added to.
        r_discard  <= w_out_next;
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        end
        if (w_drop) begin
          r_discard <= r_discard - CW'(1);
        end
        if (w_push) begin
          r_wr_ptr  <= r_wr_ptr + PW'(1);
          r_resp_pc <= r_resp_pc + ADDR_W'(4);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CW'(1);
        end
      end
    end
  end

  // Buffer storage carries no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= imem_rdata_i;
      r_buf_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_rsp_without_req: assert (!(imem_rvalid_i && (r_outstanding == '0)));
      a_no_overflow:     assert (!(w_push && !w_pop && (r_count == CW'(DEPTH))));
    end
  end

endmodule
